board_sysctl: RTL and testbench
===============================

Name: board_sysctl

Overview:
- Parametrised board-level housekeeping block for the bootloader tops.
- Synchronises the PLL lock and stretches it into a clean system reset.
- Runs a shared prescaler and drives NUM_LEDS status LEDs, each with a selectable mode (off/on/blink/PWM) and an activity-flash overlay.
- Sits between the PLL and the USB DFU core; its sys_reset feeds the DFU core's reset input.

Parameters:
- NUM_LEDS, 4, number of LED channels (1..8).
- RST_W, 6, reset stretch counter width; release occurs after 2^(RST_W-1) locked cycles.
- DIV_W, 23, prescaler width; blink period is 2^DIV_W cycles.
- PWM_W, 8, PWM resolution; PWM counter is prescaler[PWM_W-1:0]; requires PWM_W < DIV_W.
- ACT_W, 20, activity-flash hold counter width.

Ports:
- clk_48mhz  in  1  system clock from PLL.
- reset  in  1  asynchronous, active-high; clears every flop in the block.
- pll_locked  in  1  PLL lock, asynchronous to clk_48mhz.
- sys_reset  out  1  synchronous active-high reset for downstream logic.
- tick  out  1  one-cycle pulse on each prescaler wrap.
- led_mode  in  2*NUM_LEDS  per-channel mode; channel i uses bits [2i+1:2i].
- led_duty  in  PWM_W*NUM_LEDS  per-channel PWM duty.
- activity  in  NUM_LEDS  per-channel activity pulse, level-sampled each cycle.
- led  out  NUM_LEDS  registered LED drive, active-high.

Behaviour:

Reset values (on reset):
- sys_reset=1, tick=0, led=0.
- All counters 0; lock synchroniser 0.

Lock synchroniser:
- Two-flop synchroniser: lock_s = pll_locked delayed 2 cycles.

Reset stretcher:
- rst_cnt is RST_W bits.
- If lock_s=0: rst_cnt<=0.
- Else if rst_cnt[RST_W-1]=0: rst_cnt<=rst_cnt+1.
- Else: hold.
- sys_reset = ~rst_cnt[RST_W-1], registered.
- Deassertion latency from the pll_locked rise: 2 sync + 2^(RST_W-1) count + 1 output register cycles.
- Lock loss mid-operation: rst_cnt clears and sys_reset reasserts 3 cycles after pll_locked falls. A full stretch repeats on relock.
- Lock glitches shorter than 1 cycle may be missed; this is acceptable.

Prescaler:
- div_cnt is DIV_W bits; held at 0 while sys_reset=1, otherwise increments and wraps naturally.
- tick=1 for exactly one cycle when div_cnt transitions all-ones -> 0; tick is never asserted while sys_reset=1.
- blink phase = div_cnt[DIV_W-1].
- pwm_cnt = div_cnt[PWM_W-1:0].

Per-channel base value:
- mode 00: 0.
- mode 01: 1.
- mode 10: blink phase.
- mode 11: (pwm_cnt < duty_i), unsigned compare.
  - duty=0 gives constant 0.
  - duty=2^PWM_W-1 gives 1 for all but one cycle per PWM period.

Activity overlay:
- act_cnt_i is ACT_W bits.
- If activity[i]=1: act_cnt_i <= all-ones (retrigger reloads, even mid-hold).
- Else if act_cnt_i != 0: decrement.
- led[i] <= base_i XOR (act_cnt_i != 0); output is registered.
- A single-cycle activity pulse inverts the LED for 2^ACT_W-1 cycles.
- Holding activity high keeps the LED inverted until release plus 2^ACT_W-1 cycles.

Latency and reset interaction:
- A led_mode or led_duty change is visible on led 1 cycle later. Inputs need not be stable relative to tick.
- While sys_reset=1: act counters cleared, activity ignored, led forced to 0.

Test Plan:
Bench parameters: RST_W=4, DIV_W=6, PWM_W=4, ACT_W=3, NUM_LEDS=2.
- Reset stretch: reset pulse, pll_locked=1 at cycle 0 -> sys_reset falls at cycle 11 (2+8+1); tick first pulses 64 cycles after sys_reset falls.
- Lock loss: drop pll_locked for 5 cycles mid-run -> sys_reset high from 3 cycles after the fall; led=0; re-release 11 cycles after relock; prescaler restarts from 0.
- Modes: ch0 mode 10, ch1 mode 01 -> led[0] toggles every 32 cycles; led[1] constant 1; switching ch1 to 00 clears led[1] the next cycle.
- PWM: ch0 mode 11 with duty 0, 5, 15 -> high for 0, 5, and 15 of every 16 cycles respectively; duty change takes effect the next cycle.
- Activity: ch1 mode 01, 1-cycle activity[1] -> led[1]=0 for exactly 7 cycles then 1; a retrigger at the 4th cycle extends low to 4+7 cycles total; activity during sys_reset has no effect.
- Async reset mid-run: assert reset asynchronously -> sys_reset=1 and led=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/board_sysctl.sv
`default_nettype none
// ============================================================================
//  Module      : board_sysctl
//  Description : Board housekeeping: PLL-lock synchroniser, reset stretcher,
//                shared prescaler and per-channel status LED drivers.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_sysctl #(
    parameter int NUM_LEDS = 4,
    parameter int RST_W    = 6,
    parameter int DIV_W    = 23,
    parameter int PWM_W    = 8,
    parameter int ACT_W    = 20
) (
    input  logic                      clk_48mhz,
    input  logic                      reset,
    input  logic                      pll_locked,
    output logic                      sys_reset,
    output logic                      tick,
    input  logic [2*NUM_LEDS-1:0]     led_mode,
    input  logic [PWM_W*NUM_LEDS-1:0] led_duty,
    input  logic [NUM_LEDS-1:0]       activity,
    output logic [NUM_LEDS-1:0]       led
);

    localparam logic [DIV_W-1:0] c_div_max = '1;

    logic             r_lock_meta;
    logic             r_lock_s;
    logic [RST_W-1:0] r_rst_cnt;
    logic             r_sys_reset;
    logic             w_sys_reset_d;
    logic             w_hold;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_tick;
    logic             w_blink;
    logic [PWM_W-1:0] w_pwm_cnt;

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            r_rst_cnt <= '0;
        end else if (!r_lock_s) begin
            r_rst_cnt <= '0;
        end else if (!r_rst_cnt[RST_W-1]) begin
            r_rst_cnt <= r_rst_cnt + RST_W'(1);
        end
    end

    // Gating with the live lock lets sys_reset reassert in the same cycle the
    // counter clears, instead of one cycle later.
    assign w_sys_reset_d = ~(r_lock_s & r_rst_cnt[RST_W-1]);

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            r_sys_reset <= 1'b1;
        end else begin
            r_sys_reset <= w_sys_reset_d;
        end
    end

    // Covers both the current and the upcoming reset state so tick, led and
    // the counters are never non-idle while sys_reset is visible high.
    assign w_hold = r_sys_reset | w_sys_reset_d;

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (w_hold) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
            r_tick    <= (r_div_cnt == c_div_max);
        end
    end

    assign w_blink   = r_div_cnt[DIV_W-1];
    assign w_pwm_cnt = r_div_cnt[PWM_W-1:0];
    assign sys_reset = r_sys_reset;
    assign tick      = r_tick;

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
        logic [ACT_W-1:0] r_act_cnt;
        logic             r_led_q;
        logic [1:0]       w_mode;
        logic [PWM_W-1:0] w_duty;
        logic             w_base;

        assign w_mode = led_mode[2*gi +: 2];
        assign w_duty = led_duty[PWM_W*gi +: PWM_W];

        always_comb begin
            w_base = 1'b0;
            case (w_mode)
                2'b01:   w_base = 1'b1;
                2'b10:   w_base = w_blink;
                2'b11:   w_base = (w_pwm_cnt < w_duty);
                default: w_base = 1'b0;
            endcase
        end

        always_ff @(posedge clk_48mhz or posedge reset) begin
            if (reset) begin
                r_act_cnt <= '0;
                r_led_q   <= 1'b0;
            end else if (w_hold) begin
                r_act_cnt <= '0;
                r_led_q   <= 1'b0;
            end else begin
                if (activity[gi]) begin
                    r_act_cnt <= '1;
                end else if (r_act_cnt != '0) begin
                    r_act_cnt <= r_act_cnt - ACT_W'(1);
                end
                r_led_q <= w_base ^ (r_act_cnt != '0);
            end
        end

        assign led[gi] = r_led_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_board_sysctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_sysctl
//  Description : Self-checking bench for board_sysctl with a timestamp-based
//                reference model, vector table and directed corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_sysctl;

    localparam int NUM_LEDS = 2;
    localparam int RST_W    = 4;
    localparam int DIV_W    = 6;
    localparam int PWM_W    = 4;
    localparam int ACT_W    = 3;

    localparam int c_release    = 2**(RST_W-1) + 1;
    localparam int c_div_period = 2**DIV_W;
    localparam int c_pwm_period = 2**PWM_W;
    localparam int c_hold       = 2**ACT_W - 1;

    logic                      clk_48mhz = 1'b0;
    logic                      reset;
    logic                      pll_locked;
    logic                      sys_reset;
    logic                      tick;
    logic [2*NUM_LEDS-1:0]     led_mode;
    logic [PWM_W*NUM_LEDS-1:0] led_duty;
    logic [NUM_LEDS-1:0]       activity;
    logic [NUM_LEDS-1:0]       led;

    board_sysctl #(
        .NUM_LEDS (NUM_LEDS),
        .RST_W    (RST_W),
        .DIV_W    (DIV_W),
        .PWM_W    (PWM_W),
        .ACT_W    (ACT_W)
    ) u_dut (
        .clk_48mhz  (clk_48mhz),
        .reset      (reset),
        .pll_locked (pll_locked),
        .sys_reset  (sys_reset),
        .tick       (tick),
        .led_mode   (led_mode),
        .led_duty   (led_duty),
        .activity   (activity),
        .led        (led)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    int errors = 0;
    int checks = 0;

    // Reference model state: lock run lengths, cycles since release,
    // and the edge index of the last accepted activity pulse per channel.
    int m_edge;
    int m_run;
    int m_run_d;
    bit m_sr;
    int m_pc;
    int m_last_act [NUM_LEDS];
    bit                exp_sr;
    bit                exp_tick;
    logic [NUM_LEDS-1:0] exp_led;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 0;
        m_run_d = 0;
        m_sr    = 1'b1;
        m_pc    = 0;
        for (int i = 0; i < NUM_LEDS; i++) m_last_act[i] = -1000;
        exp_sr   = 1'b1;
        exp_tick = 1'b0;
        exp_led  = '0;
    endtask

    task automatic model_edge();
        bit sr_new;
        bit hold;
        bit base;
        bit act_on;
        int div_prev;
        int duty;
        logic [1:0] mode;
        m_edge++;
        // Release once pll_locked has been seen high for c_release samples,
        // observed through the two-stage synchroniser delay.
        sr_new   = !(m_run_d >= c_release);
        m_run_d  = m_run;
        m_run    = pll_locked ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
        div_prev = m_pc % c_div_period;
        hold     = sr_new || m_sr;
        for (int i = 0; i < NUM_LEDS; i++) begin
            mode = led_mode[2*i +: 2];
            duty = int'(led_duty[PWM_W*i +: PWM_W]);
            case (mode)
                2'b00:   base = 1'b0;
                2'b01:   base = 1'b1;
                2'b10:   base = (div_prev >= c_div_period / 2);
                default: base = ((div_prev % c_pwm_period) < duty);
            endcase
            act_on     = ((m_edge - 1 - m_last_act[i]) < c_hold);
            exp_led[i] = hold ? 1'b0 : (base ^ act_on);
            if (hold) m_last_act[i] = -1000;
            else if (activity[i]) m_last_act[i] = m_edge;
        end
        m_pc     = hold ? 0 : m_pc + 1;
        exp_tick = !hold && (m_pc % c_div_period == 0);
        exp_sr   = sr_new;
        m_sr     = sr_new;
    endtask

    task automatic step();
        @(posedge clk_48mhz);
        if (reset) model_reset();
        else model_edge();
        #1;
        chk("sys_reset", sys_reset, exp_sr);
        chk("tick", tick, exp_tick);
        chk("led", led, exp_led);
    endtask

    typedef struct {
        logic [1:0] mode0;
        logic [1:0] mode1;
        int duty0;
        int duty1;
        int window;
        int exp0;
        int exp1;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int low;
        int c0;
        int c1;
        int lock_low_left;
        logic prev;

        vecs[0] = '{2'b11, 2'b01,  0,  0, 16,  0, 16};
        vecs[1] = '{2'b11, 2'b11,  5, 15, 16,  5, 15};
        vecs[2] = '{2'b11, 2'b00, 15,  3, 16, 15,  0};
        vecs[3] = '{2'b10, 2'b11,  0,  8, 64, 32, 32};
        vecs[4] = '{2'b01, 2'b11,  0,  1, 32, 32,  2};

        m_edge     = 0;
        reset      = 1'b1;
        pll_locked = 1'b1;
        led_mode   = '0;
        led_duty   = '0;
        activity   = '0;
        model_reset();
        repeat (3) step();
        chk("reset_sys_reset", sys_reset, 1);
        chk("reset_tick", tick, 0);
        chk("reset_led", led, 0);

        // Stretch: lock already high, reset released right after an edge.
        reset = 1'b0;
        n = 0;
        do begin step(); n++; end while (sys_reset && n < 40);
        chk("release_latency", n, 11);
        n = 0;
        do begin step(); n++; end while (!tick && n < 200);
        chk("first_tick", n, 64);

        // Modes: ch0 blink, ch1 on.
        led_mode = {2'b01, 2'b10};
        step();
        prev = led[0];
        n = 0;
        while (led[0] == prev && n < 100) begin step(); n++; end
        prev = led[0];
        n = 0;
        while (led[0] == prev && n < 100) begin step(); n++; end
        chk("blink_half_period", n, 32);
        chk("mode01_on", led[1], 1);
        led_mode[3:2] = 2'b00;
        step();
        chk("mode00_next_cycle", led[1], 0);

        for (int v = 0; v < 5; v++) begin
            led_mode = {vecs[v].mode1, vecs[v].mode0};
            led_duty = {PWM_W'(vecs[v].duty1), PWM_W'(vecs[v].duty0)};
            step();
            c0 = 0;
            c1 = 0;
            for (int k = 0; k < vecs[v].window; k++) begin
                step();
                c0 += int'(led[0]);
                c1 += int'(led[1]);
            end
            chk($sformatf("table%0d_ch0_high", v), c0, vecs[v].exp0);
            chk($sformatf("table%0d_ch1_high", v), c1, vecs[v].exp1);
        end

        led_mode = {2'b11, 2'b11};
        led_duty = {4'd15, 4'd15};
        repeat (3) step();
        led_duty = {4'd15, 4'd0};
        step();
        chk("duty0_next_cycle", led[0], 0);

        // Activity: single pulse then retrigger.
        led_mode = {2'b01, 2'b00};
        repeat (2) step();
        chk("act_base_on", led[1], 1);
        activity = 2'b10;
        step();
        activity = 2'b00;
        low = 0;
        n = 0;
        do begin step(); n++; if (!led[1]) low++; end while (!(low > 0 && led[1]) && n < 30);
        chk("act_single_low", low, 7);

        activity = 2'b10;
        step();
        activity = 2'b00;
        low = 0;
        for (int k = 0; k < 3; k++) begin step(); if (!led[1]) low++; end
        activity = 2'b10;
        step();
        if (!led[1]) low++;
        activity = 2'b00;
        n = 0;
        do begin step(); n++; if (!led[1]) low++; end while (led[1] == 1'b0 && n < 30);
        chk("act_retrigger_low", low, 11);

        // Lock loss for 5 cycles, with activity pulsed while in reset.
        led_mode   = {2'b01, 2'b00};
        pll_locked = 1'b0;
        n = 0;
        do begin step(); n++; end while (!sys_reset && n < 20);
        chk("lockloss_latency", n, 3);
        chk("lockloss_led", led, 0);
        activity = 2'b11;
        step();
        activity = 2'b00;
        step();
        pll_locked = 1'b1;
        n = 0;
        do begin step(); n++; end while (sys_reset && n < 40);
        chk("relock_latency", n, 11);
        step();
        chk("act_in_reset_ignored", led[1], 1);
        n = 1;
        do begin step(); n++; end while (!tick && n < 200);
        chk("relock_tick", n, 64);

        // Randomised run against the model.
        lock_low_left = 0;
        for (int k = 0; k < 1500; k++) begin
            if (lock_low_left > 0) begin
                pll_locked = 1'b0;
                lock_low_left--;
            end else begin
                pll_locked = 1'b1;
                if ($urandom_range(0, 299) == 0) lock_low_left = $urandom_range(1, 12);
            end
            for (int i = 0; i < NUM_LEDS; i++) activity[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) begin
                led_mode = ($urandom);
                led_duty = ($urandom);
            end
            step();
        end

        // Asynchronous reset mid-cycle.
        pll_locked = 1'b1;
        activity   = '0;
        led_mode   = {2'b01, 2'b01};
        n = 0;
        do begin step(); n++; end while (sys_reset && n < 40);
        repeat (2) step();
        chk("pre_async_led", led, 3);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_sys_reset", sys_reset, 1);
        chk("async_led", led, 0);
        chk("async_tick", tick, 0);
        repeat (2) step();
        reset = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
